// File: rtl/router_wrap_link_pkg.sv
// Shared definitions for the credit-based link transmitter.
//   DATA_W_DEF : default flit payload width
//   CREDIT_W   : width of the credit counter (supports up to 15 credits)
//   tx_state_e : transmitter status FSM encoding
//   tx_state_of: maps buffer occupancy and credit availability to a state
package router_wrap_link_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CREDIT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // buffer empty
    ST_SEND  = 2'd1,  // buffer holds flits and a credit is available
    ST_STALL = 2'd2   // buffer holds flits but the receiver is full
  } tx_state_e;

  function automatic tx_state_e tx_state_of(input logic fifo_nonempty,
                                            input logic credit_avail);
    tx_state_e st;
    if (!fifo_nonempty)    st = ST_IDLE;
    else if (credit_avail) st = ST_SEND;
    else                   st = ST_STALL;
    return st;
  endfunction

endpackage

// File: rtl/router_wrap_tx_fifo.sv
// Transmit buffer: circular FIFO with wrapping read/write pointers.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   i_push, i_data  : write one entry (ignored while full)
//   i_pop           : drop the head entry (ignored while empty)
//   o_head          : current head entry (undefined while empty)
//   o_count         : number of entries held, 0..DEPTH
module router_wrap_tx_fifo
  import router_wrap_link_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push && (r_count != FULL_CNT);
  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/router_wrap_credit_tx.sv
// Credit-based link transmitter. Flits from a local source are buffered and
// launched onto the link one per cycle while the receiver has granted credit.
// Handshakes:
//   local side : a flit transfers on a rising edge where in_valid && in_ready;
//                in_ready depends only on the registered buffer count (and is
//                low while reset is asserted).
//   link side  : flit_valid is a one-cycle pulse per flit, each consuming one
//                credit; credit_in is a one-cycle pulse returning one credit.
// Ports:
//   clk, reset             : clock, synchronous active-low reset
//   in_valid/in_data/in_ready : local flit input
//   flit_valid/flit_data   : registered link output (data holds when idle)
//   credit_in              : receiver freed one slot
//   credit_cnt             : credits currently available
//   fifo_cnt               : flits currently buffered
//   credit_err             : sticky, a credit arrived while already at max
//   o_dbg_state            : status FSM (tx_state_e encoding)
module router_wrap_credit_tx
  import router_wrap_link_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        flit_valid,
  output logic [DATA_W-1:0]           flit_data,
  input  logic                        credit_in,
  output logic [CREDIT_W-1:0]         credit_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        credit_err,
  output logic [1:0]                  o_dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CREDIT_W-1:0] MAX_CREDITS = CREDIT_W'(CREDITS);

  logic [CNT_W-1:0]    w_fifo_cnt;
  logic [CNT_W-1:0]    w_fifo_nxt;
  logic [DATA_W-1:0]   w_head;
  logic                w_push;
  logic                w_launch;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_err_set;
  tx_state_e           w_state_nxt;

  logic [CREDIT_W-1:0] r_credit_cnt;
  logic                r_credit_err;
  logic                r_flit_valid;
  logic [DATA_W-1:0]   r_flit_data;
  tx_state_e           r_state;

  router_wrap_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_launch),
    .o_head  (w_head),
    .o_count (w_fifo_cnt)
  );

  // Registered count only: a launch in the same cycle cannot reopen a full
  // buffer, and an empty buffer never bypasses straight to the link.
  assign in_ready = reset && (w_fifo_cnt < FULL_CNT);
  assign w_push   = in_valid && in_ready;
  // Uses the registered credit count, so a credit arriving at zero only
  // makes the next cycle eligible.
  assign w_launch = reset && (w_fifo_cnt != '0) && (r_credit_cnt != '0);

  always_comb begin
    w_credit_nxt = r_credit_cnt;
    w_err_set    = 1'b0;
    case ({credit_in, w_launch})
      2'b10: begin
        if (r_credit_cnt == MAX_CREDITS) w_err_set = 1'b1;
        else                             w_credit_nxt = r_credit_cnt + 1'b1;
      end
      2'b01:   w_credit_nxt = r_credit_cnt - 1'b1;
      default: w_credit_nxt = r_credit_cnt;
    endcase
  end

  always_comb begin
    w_fifo_nxt = w_fifo_cnt;
    case ({w_push, w_launch})
      2'b10:   w_fifo_nxt = w_fifo_cnt + 1'b1;
      2'b01:   w_fifo_nxt = w_fifo_cnt - 1'b1;
      default: w_fifo_nxt = w_fifo_cnt;
    endcase
  end

  assign w_state_nxt = tx_state_of(w_fifo_nxt != '0, w_credit_nxt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credit_cnt <= MAX_CREDITS;
      r_credit_err <= 1'b0;
      r_flit_valid <= 1'b0;
      r_flit_data  <= '0;
      r_state      <= ST_IDLE;
    end else begin
      r_credit_cnt <= w_credit_nxt;
      r_credit_err <= r_credit_err | w_err_set;
      r_flit_valid <= w_launch;
      if (w_launch) r_flit_data <= w_head;
      r_state      <= w_state_nxt;
    end
  end

  assign flit_valid  = r_flit_valid;
  assign flit_data   = r_flit_data;
  assign credit_cnt  = r_credit_cnt;
  assign fifo_cnt    = w_fifo_cnt;
  assign credit_err  = r_credit_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_router_wrap_credit_tx.sv
// Bench for router_wrap_credit_tx: a vector table for reset/basic/error
// behaviour, hand-written multi-cycle sequences, and randomized traffic, all
// checked against a queue-based behavioural model of the link transmitter.
module tb_router_wrap_credit_tx;
  import router_wrap_link_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CRED  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flit_valid;
  logic [DW-1:0] flit_data;
  logic          credit_in;
  logic [3:0]    credit_cnt;
  logic [2:0]    fifo_cnt;
  logic          credit_err;
  logic [1:0]    dbg_state;

  router_wrap_credit_tx #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .CREDITS    (CRED)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flit_valid  (flit_valid),
    .flit_data   (flit_data),
    .credit_in   (credit_in),
    .credit_cnt  (credit_cnt),
    .fifo_cnt    (fifo_cnt),
    .credit_err  (credit_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_model = 1'b0;

  logic [DW-1:0] exp_q[$];  // flits the transmitter should be holding
  int            m_credits;
  bit            m_fv;
  logic [DW-1:0] m_fd;
  bit            m_err;

  // Values sampled from the DUT in the most recent cycle.
  logic          obs_fv, obs_rdy, obs_err;
  logic [DW-1:0] obs_fd;
  logic [3:0]    obs_cc;
  logic [2:0]    obs_fc;
  logic [1:0]    obs_st;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] m_state();
    if (exp_q.size() == 0) return ST_IDLE;
    if (m_credits > 0)     return ST_SEND;
    return ST_STALL;
  endfunction

  // One clock edge of the transmitter, described by its rules: launch the
  // oldest flit if one is held and a credit exists, settle the credit count,
  // then append an accepted flit.
  task automatic model_step(input bit r, input bit v, input logic [DW-1:0] d, input bit c);
    bit launch;
    bit accept;
    if (!r) begin
      exp_q.delete();
      m_credits = CRED;
      m_fv      = 1'b0;
      m_fd      = '0;
      m_err     = 1'b0;
    end else begin
      accept = v && (exp_q.size() < DEPTH);
      launch = (exp_q.size() > 0) && (m_credits > 0);
      if (launch) begin
        m_fd = exp_q.pop_front();
        m_fv = 1'b1;
      end else begin
        m_fv = 1'b0;
      end
      if (c && !launch && m_credits == CRED) m_err = 1'b1;
      else m_credits = m_credits + int'(c) - int'(launch);
      if (accept) exp_q.push_back(d);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit v, input logic [DW-1:0] d, input bit c);
    @(negedge clk);
    rst_n     = r;
    in_valid  = v;
    in_data   = d;
    credit_in = c;
    #1;
    obs_fv  = flit_valid;
    obs_fd  = flit_data;
    obs_rdy = in_ready;
    obs_cc  = credit_cnt;
    obs_fc  = fifo_cnt;
    obs_err = credit_err;
    obs_st  = dbg_state;
    if (chk_model) begin
      chk("in_ready",   32'(obs_rdy), 32'(r && (exp_q.size() < DEPTH)));
      chk("credit_cnt", 32'(obs_cc),  32'(m_credits));
      chk("fifo_cnt",   32'(obs_fc),  32'(exp_q.size()));
      chk("flit_valid", 32'(obs_fv),  32'(m_fv));
      chk("flit_data",  obs_fd,       m_fd);
      chk("credit_err", 32'(obs_err), 32'(m_err));
      chk("state",      32'(obs_st),  32'(m_state()));
    end
    @(posedge clk);
    model_step(r, v, d, c);
    cyc++;
  endtask

  task automatic reset_dut();
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst_n;
    logic          v;
    logic [DW-1:0] d;
    logic          ci;
    logic [3:0]    e_cc;
    logic [2:0]    e_fc;
    logic          e_fv;
    logic [DW-1:0] e_fd;
    logic          e_rdy;
    logic          e_err;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vt[NVEC];

  int            ret_q[$];
  logic [DW-1:0] got_q[$];
  int            first_fv;
  int            n_fv;
  logic [DW-1:0] d_next;
  bit            r_b, v_b, c_b;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; credit_in = 1'b0;
    model_step(1'b0, 1'b0, '0, 1'b0);

    //            rst v  data    ci   cc    fc   fv  fd      rdy  err
    vt[0]  = '{1'b0,1'b0,32'h00,1'b0, 4'd4,3'd0,1'b0,32'h00,1'b0,1'b0};
    vt[1]  = '{1'b0,1'b0,32'h00,1'b0, 4'd4,3'd0,1'b0,32'h00,1'b0,1'b0};
    vt[2]  = '{1'b1,1'b1,32'h11,1'b0, 4'd4,3'd0,1'b0,32'h00,1'b1,1'b0};
    vt[3]  = '{1'b1,1'b1,32'h22,1'b0, 4'd4,3'd1,1'b0,32'h00,1'b1,1'b0};
    vt[4]  = '{1'b1,1'b0,32'h00,1'b1, 4'd3,3'd1,1'b1,32'h11,1'b1,1'b0};
    vt[5]  = '{1'b1,1'b0,32'h00,1'b0, 4'd3,3'd0,1'b1,32'h22,1'b1,1'b0};
    vt[6]  = '{1'b1,1'b0,32'h00,1'b1, 4'd3,3'd0,1'b0,32'h22,1'b1,1'b0};
    vt[7]  = '{1'b1,1'b0,32'h00,1'b1, 4'd4,3'd0,1'b0,32'h22,1'b1,1'b0};
    vt[8]  = '{1'b1,1'b0,32'h00,1'b0, 4'd4,3'd0,1'b0,32'h22,1'b1,1'b1};
    vt[9]  = '{1'b0,1'b0,32'h00,1'b0, 4'd4,3'd0,1'b0,32'h22,1'b0,1'b1};
    vt[10] = '{1'b1,1'b0,32'h00,1'b0, 4'd4,3'd0,1'b0,32'h00,1'b1,1'b0};

    for (int i = 0; i < NVEC; i++) begin
      cycle(vt[i].rst_n, vt[i].v, vt[i].d, vt[i].ci);
      chk("tbl_credit_cnt", 32'(obs_cc),  32'(vt[i].e_cc));
      chk("tbl_fifo_cnt",   32'(obs_fc),  32'(vt[i].e_fc));
      chk("tbl_flit_valid", 32'(obs_fv),  32'(vt[i].e_fv));
      chk("tbl_flit_data",  obs_fd,       vt[i].e_fd);
      chk("tbl_in_ready",   32'(obs_rdy), 32'(vt[i].e_rdy));
      chk("tbl_credit_err", 32'(obs_err), 32'(vt[i].e_err));
    end

    chk_model = 1'b1;

    // Streaming: six flits back-to-back, each credit returned 3 cycles after
    // its flit appears on the link.
    reset_dut();
    ret_q.delete();
    got_q.delete();
    first_fv = -1;
    for (int t = 0; t < 25; t++) begin
      c_b = 1'b0;
      if (ret_q.size() > 0 && ret_q[0] == t) begin
        c_b = 1'b1;
        void'(ret_q.pop_front());
      end
      cycle(1'b1, t < 6, 32'hA0 + 32'(t), c_b);
      if (obs_fv) begin
        got_q.push_back(obs_fd);
        ret_q.push_back(t + 3);
        if (first_fv < 0) first_fv = t;
      end
    end
    chk("stream_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < got_q.size(); i++)
      chk("stream_order", got_q[i], 32'hA0 + 32'(i));
    chk("stream_latency", 32'(first_fv), 32'd2);

    // Credit exhaustion: offer flits continuously with no credit returned.
    reset_dut();
    n_fv   = 0;
    d_next = 32'hB0;
    for (int t = 0; t < 12; t++) begin
      cycle(1'b1, 1'b1, d_next, 1'b0);
      if (obs_rdy) d_next = d_next + 1;
      if (obs_fv) n_fv++;
    end
    cycle(1'b1, 1'b0, '0, 1'b0);
    if (obs_fv) n_fv++;
    chk("exh_pulses",   32'(n_fv),    32'd4);
    chk("exh_fifo_cnt", 32'(obs_fc),  32'd4);
    chk("exh_in_ready", 32'(obs_rdy), 32'd0);
    chk("exh_state",    32'(obs_st),  32'(ST_STALL));
    chk("exh_credits",  32'(obs_cc),  32'd0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("exh_no_launch_on_credit", 32'(obs_fv), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("exh_fifth_valid", 32'(obs_fv), 32'd1);
    chk("exh_fifth_data",  obs_fd,      32'hB4);

    // Launch and credit return in the same cycle at credit_cnt == 2.
    reset_dut();
    for (int t = 0; t < 4; t++) begin
      cycle(1'b1, 1'b1, 32'hC0 + 32'(t), t == 3);
      if (t == 3) chk("simul_pre_cc", 32'(obs_cc), 32'd2);
    end
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("simul_cc",    32'(obs_cc), 32'd2);
    chk("simul_valid", 32'(obs_fv), 32'd1);
    chk("simul_data",  obs_fd,      32'hC2);

    // Reset while three flits are buffered and traffic is still offered.
    reset_dut();
    for (int t = 0; t < 7; t++) cycle(1'b1, 1'b1, 32'hD0 + 32'(t), 1'b0);
    cycle(1'b0, 1'b1, 32'hEE, 1'b1);
    chk("mid_fifo_pre", 32'(obs_fc), 32'd3);
    n_fv = 0;
    cycle(1'b0, 1'b1, 32'hEF, 1'b1);
    if (obs_fv) n_fv++;
    for (int t = 0; t < 8; t++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      if (obs_fv) n_fv++;
      if (t == 0) begin
        chk("mid_cc",  32'(obs_cc),  32'd4);
        chk("mid_fc",  32'(obs_fc),  32'd0);
        chk("mid_rdy", 32'(obs_rdy), 32'd1);
        chk("mid_fd",  obs_fd,       32'd0);
      end
    end
    chk("mid_no_flits", 32'(n_fv), 32'd0);

    // Randomized traffic; credits mostly respect the protocol with an
    // occasional surplus pulse, and rare resets.
    for (int t = 0; t < 400; t++) begin
      r_b = ($urandom_range(0, 49) != 0);
      v_b = ($urandom_range(0, 99) < 60);
      if (m_credits < CRED) c_b = ($urandom_range(0, 99) < 40);
      else                  c_b = ($urandom_range(0, 99) < 3);
      cycle(r_b, v_b, $urandom, c_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
